// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - multi-channel PWM generator, shared edge/center-aligned counter
// Period, mode and duty writes land in shadow registers and go active at the period boundary.
module pwm_multi_channel #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int CNT_W          = 32,
  parameter int NUM_CH         = 4,
  parameter int DEFAULT_PERIOD = CLK_FREQ / 50,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n_a,
  input  logic              enable,
  input  logic              period_wr,
  input  logic [CNT_W-1:0]  period_in,
  input  logic              mode_in,
  input  logic              duty_wr,
  input  logic [CH_W-1:0]   duty_ch,
  input  logic [CNT_W-1:0]  duty_in,
  output logic [CNT_W-1:0]  counter_out,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);

  logic [CNT_W-1:0]  r_cnt;
  logic              r_dir;
  logic              r_en_d;
  logic              r_pstart;
  logic [NUM_CH-1:0] r_pwm;
  logic [CNT_W-1:0]  r_period_sh;
  logic [CNT_W-1:0]  r_period_act;
  logic              r_mode_sh;
  logic              r_mode_act;
  logic [CNT_W-1:0]  r_duty_sh  [NUM_CH];
  logic [CNT_W-1:0]  r_duty_act [NUM_CH];

  logic [CNT_W-1:0]  w_period_nxt;
  logic              w_mode_nxt;
  logic [CNT_W-1:0]  w_duty_nxt [NUM_CH];
  logic              w_at_top;
  logic              w_boundary;

  // Shadow values including a same-cycle write, so a boundary write is taken through
  always_comb begin
    w_period_nxt = period_wr ? period_in : r_period_sh;
    w_mode_nxt   = period_wr ? mode_in : r_mode_sh;
    for (int i = 0; i < NUM_CH; i++) begin
      w_duty_nxt[i] = (duty_wr && duty_ch == CH_W'(i)) ? duty_in : r_duty_sh[i];
    end
  end

  // First enabled cycle after idle restarts the frame like a boundary
  always_comb begin
    w_at_top   = r_cnt >= r_period_act - ONE;
    w_boundary = 1'b0;
    if (!r_en_d || r_period_act <= ONE) begin
      w_boundary = 1'b1;
    end else if (!r_mode_act) begin
      w_boundary = w_at_top;
    end else begin
      w_boundary = (r_dir && r_cnt <= ONE) || (r_period_act <= TWO && w_at_top);
    end
  end

  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      r_cnt        <= '0;
      r_dir        <= 1'b0;
      r_en_d       <= 1'b0;
      r_pstart     <= 1'b0;
      r_pwm        <= '0;
      r_period_sh  <= DEF_P;
      r_period_act <= DEF_P;
      r_mode_sh    <= 1'b0;
      r_mode_act   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_duty_sh[i]  <= '0;
        r_duty_act[i] <= '0;
      end
    end else begin
      r_period_sh <= w_period_nxt;
      r_mode_sh   <= w_mode_nxt;
      r_duty_sh   <= w_duty_nxt;
      r_en_d      <= enable;
      if (!enable) begin
        r_cnt        <= '0;
        r_dir        <= 1'b0;
        r_pstart     <= 1'b0;
        r_pwm        <= '0;
        r_period_act <= w_period_nxt;
        r_mode_act   <= w_mode_nxt;
        r_duty_act   <= w_duty_nxt;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          r_pwm[i] <= r_en_d && (r_cnt < r_duty_act[i]);
        end
        r_pstart <= w_boundary;
        if (w_boundary) begin
          r_cnt        <= '0;
          r_dir        <= 1'b0;
          r_period_act <= w_period_nxt;
          r_mode_act   <= w_mode_nxt;
          r_duty_act   <= w_duty_nxt;
        end else if (!r_mode_act) begin
          r_cnt <= r_cnt + ONE;
        end else if (!r_dir && w_at_top) begin
          r_dir <= 1'b1;
          r_cnt <= r_cnt - ONE;
        end else if (r_dir) begin
          r_cnt <= r_cnt - ONE;
        end else begin
          r_cnt <= r_cnt + ONE;
        end
      end
    end
  end

  assign counter_out  = r_cnt;
  assign pwm_out      = r_pwm;
  assign period_start = r_pstart;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb/tb_pwm_multi_channel.sv - scoreboard bench for pwm_multi_channel (CNT_W=8, NUM_CH=4 and 6)
module tb_pwm_multi_channel;
  localparam int W   = 8;
  localparam int NCH = 4;
  localparam logic [W-1:0] DEF_P = 8'd12;

  logic clk = 1'b0;
  logic rst_n_a, enable, period_wr, mode_in, duty_wr, duty_wr6;
  logic [W-1:0] period_in, duty_in;
  logic [1:0] duty_ch;
  logic [2:0] duty_ch6;
  logic [W-1:0] counter_out, counter6;
  logic [NCH-1:0] pwm_out;
  logic [5:0] pwm6;
  logic period_start, ps6;

  int total = 0;
  int bad = 0;
  int hi, psn, hi5, lo;

  typedef struct packed {
    logic [W-1:0]   cnt;
    logic [NCH-1:0] pwm;
    logic           ps;
  } exp_t;
  exp_t sb[$];

  // frame-position model: counter value derived from position within the frame
  logic [W-1:0]   m_psh, m_pact;
  logic           m_msh, m_mact;
  logic [W-1:0]   m_dsh [NCH];
  logic [W-1:0]   m_dact [NCH];
  logic [NCH-1:0] m_pwm;
  logic           m_ps;
  logic           m_run;
  int             m_pos;

  always #5 clk = ~clk;

  pwm_multi_channel #(.CLK_FREQ(600), .CNT_W(W), .NUM_CH(NCH), .DEFAULT_PERIOD(12)) dut (
    .clk(clk), .rst_n_a(rst_n_a), .enable(enable),
    .period_wr(period_wr), .period_in(period_in), .mode_in(mode_in),
    .duty_wr(duty_wr), .duty_ch(duty_ch), .duty_in(duty_in),
    .counter_out(counter_out), .pwm_out(pwm_out), .period_start(period_start)
  );

  pwm_multi_channel #(.CLK_FREQ(600), .CNT_W(W), .NUM_CH(6), .DEFAULT_PERIOD(12)) dut6 (
    .clk(clk), .rst_n_a(rst_n_a), .enable(enable),
    .period_wr(period_wr), .period_in(period_in), .mode_in(mode_in),
    .duty_wr(duty_wr6), .duty_ch(duty_ch6), .duty_in(duty_in),
    .counter_out(counter6), .pwm_out(pwm6), .period_start(ps6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int frame_len();
    if (m_pact <= 1) return 1;
    return m_mact ? 2 * (int'(m_pact) - 1) : int'(m_pact);
  endfunction

  function automatic logic [W-1:0] exp_cnt();
    if (!m_run || m_pact <= 1) return '0;
    if (!m_mact || m_pos < int'(m_pact)) return W'(m_pos);
    return W'(2 * (int'(m_pact) - 1) - m_pos);
  endfunction

  task automatic model_reset();
    m_psh = DEF_P; m_pact = DEF_P; m_msh = 1'b0; m_mact = 1'b0;
    for (int i = 0; i < NCH; i++) begin m_dsh[i] = '0; m_dact[i] = '0; end
    m_pwm = '0; m_ps = 1'b0; m_run = 1'b0; m_pos = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] psn_l, old;
    logic msn;
    logic [W-1:0] dsn [NCH];
    old   = exp_cnt();
    psn_l = period_wr ? period_in : m_psh;
    msn   = period_wr ? mode_in : m_msh;
    for (int i = 0; i < NCH; i++) dsn[i] = (duty_wr && int'(duty_ch) == i) ? duty_in : m_dsh[i];
    if (!enable) begin
      m_run = 1'b0; m_pos = 0; m_pwm = '0; m_ps = 1'b0;
      m_pact = psn_l; m_mact = msn;
      for (int i = 0; i < NCH; i++) m_dact[i] = dsn[i];
    end else begin
      for (int i = 0; i < NCH; i++) m_pwm[i] = m_run && (old < m_dact[i]);
      if (!m_run || m_pos >= frame_len() - 1) begin
        m_run = 1'b1; m_pos = 0; m_ps = 1'b1;
        m_pact = psn_l; m_mact = msn;
        for (int i = 0; i < NCH; i++) m_dact[i] = dsn[i];
      end else begin
        m_pos++; m_ps = 1'b0;
      end
    end
    m_psh = psn_l; m_msh = msn;
    for (int i = 0; i < NCH; i++) m_dsh[i] = dsn[i];
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    if (!rst_n_a) model_reset(); else model_edge();
    e.cnt = exp_cnt(); e.pwm = m_pwm; e.ps = m_ps;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check("cnt", counter_out, e.cnt);
    check("pwm", pwm_out, e.pwm);
    check("pstart", period_start, e.ps);
    check("cnt6", counter6, e.cnt);
    check("pstart6", ps6, e.ps);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr_period(input logic [W-1:0] p, input logic m);
    period_wr = 1'b1; period_in = p; mode_in = m;
    tick();
    period_wr = 1'b0;
  endtask

  task automatic wr_duty(input logic [1:0] ch, input logic [W-1:0] d);
    duty_wr = 1'b1; duty_ch = ch; duty_in = d;
    tick();
    duty_wr = 1'b0;
  endtask

  task automatic wait_cnt(input logic [W-1:0] v);
    int n = 0;
    while (exp_cnt() != v && n < 64) begin tick(); n++; end
    check("wait_cnt", counter_out, v);
  endtask

  task automatic count_high(input int n, input int b, output int h, output int p);
    h = 0; p = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      h += int'(pwm_out[b]);
      p += int'(period_start);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n_a = 1'b0; enable = 1'b0; period_wr = 1'b0; period_in = '0; mode_in = 1'b0;
    duty_wr = 1'b0; duty_ch = '0; duty_in = '0; duty_wr6 = 1'b0; duty_ch6 = '0;
    model_reset();
    run(3);
    check("rst_cnt", counter_out, 0);
    check("rst_pwm", pwm_out, 0);
    check("rst_ps", period_start, 0);
    rst_n_a = 1'b1;

    // edge-aligned P=10
    wr_period(8'd10, 1'b0);
    wr_duty(2'd0, 8'd3);
    wr_duty(2'd1, 8'd2);
    wr_duty(2'd3, 8'd0);
    enable = 1'b1;
    run(5);
    count_high(30, 0, hi, psn);
    check("edge_hi0", hi, 9);
    check("edge_ps", psn, 3);
    count_high(20, 3, hi, psn);
    check("zero_hi3", hi, 0);

    // shadowed duty write mid-frame
    wait_cnt(8'd4);
    wr_duty(2'd1, 8'd7);
    run(25);
    count_high(10, 1, hi, psn);
    check("shadow_hi1", hi, 7);

    // asynchronous reset mid-period
    wait_cnt(8'd6);
    #2 rst_n_a = 1'b0;
    #1;
    check("arst_cnt", counter_out, 0);
    check("arst_pwm", pwm_out, 0);
    check("arst_ps", period_start, 0);
    run(2);
    rst_n_a = 1'b1;
    wait_cnt(8'd11);
    run(3);

    // center-aligned P=5
    wr_duty(2'd2, 8'd2);
    wr_period(8'd5, 1'b1);
    run(20);
    count_high(16, 2, hi, psn);
    check("ctr_hi2", hi, 6);
    check("ctr_ps", psn, 2);

    // same-cycle period+duty write, back to edge mode, D=P gives 100%
    period_wr = 1'b1; period_in = 8'd10; mode_in = 1'b0;
    duty_wr = 1'b1; duty_ch = 2'd3; duty_in = 8'd10;
    tick();
    period_wr = 1'b0; duty_wr = 1'b0;
    run(25);
    count_high(20, 3, hi, psn);
    check("full_hi3", hi, 20);
    check("edge2_ps", psn, 2);

    // degenerate periods
    wr_duty(2'd0, 8'd3);
    wr_period(8'd1, 1'b0);
    run(12);
    count_high(8, 0, hi, psn);
    check("p1_ps", psn, 8);
    check("p1_hi0", hi, 8);
    check("p1_cnt", counter_out, 0);
    wr_period(8'd2, 1'b1);
    run(10);
    wr_period(8'd0, 1'b0);
    run(6);

    // idle: writes apply at once, restart on enable
    enable = 1'b0;
    run(3);
    wr_period(8'd20, 1'b0);
    tick();
    check("idle_cnt", counter_out, 0);
    check("idle_pwm", pwm_out, 0);
    enable = 1'b1;
    tick();
    check("en_ps", period_start, 1);
    count_high(19, 0, hi, psn);
    check("first_frame_ps", psn, 0);
    tick();
    check("frame20", period_start, 1);

    // channel range on the 6-channel build
    enable = 1'b0;
    wr_period(8'd10, 1'b0);
    duty_wr6 = 1'b1; duty_ch6 = 3'd5; duty_in = 8'd4;
    tick();
    duty_ch6 = 3'd6; duty_in = 8'd9;
    tick();
    duty_ch6 = 3'd7;
    tick();
    duty_wr6 = 1'b0;
    enable = 1'b1;
    run(3);
    hi5 = 0; lo = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      hi5 += int'(pwm6[5]);
      lo  += int'(|pwm6[4:0]);
    end
    check("ch5_hi", hi5, 8);
    check("ch_lo", lo, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
